// File: rtl/fifo_umbral_pkg.sv
// Shared defaults and types for the fifo_umbral queue block.
// The FIFO_UMBRAL_HWM_EN macro adds a high-water-mark output to the interface and top.
package fifo_umbral_pkg;

    localparam int DATA_W = 6;
    localparam int ADDR_W = 3;
    localparam int U_W    = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_OVF  = 2'd1,
        ERR_UNF  = 2'd2
    } err_cause_e;

endpackage

// File: rtl/fifo_umbral_if.sv
// Push/pop/threshold bundle between a queue user (master) and fifo_umbral (slave).
// With FIFO_UMBRAL_HWM_EN defined, the bundle also carries the high-water mark.
interface fifo_umbral_if #(
    parameter int DATA_W = fifo_umbral_pkg::DATA_W,
    parameter int ADDR_W = fifo_umbral_pkg::ADDR_W,
    parameter int U_W    = fifo_umbral_pkg::U_W
);
    import fifo_umbral_pkg::*;

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [U_W-1:0]    umbral_alto;
    logic [U_W-1:0]    umbral_bajo;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic              error;
`ifdef FIFO_UMBRAL_HWM_EN
    logic [ADDR_W:0]   hwm;
`endif

    modport master (
        output wr_en, data_in, rd_en, umbral_alto, umbral_bajo,
        input  data_out, valid_out, count, empty, full,
        input  almost_full, almost_empty, error
`ifdef FIFO_UMBRAL_HWM_EN
        , input hwm
`endif
    );

    modport slave (
        input  wr_en, data_in, rd_en, umbral_alto, umbral_bajo,
        output data_out, valid_out, count, empty, full,
        output almost_full, almost_empty, error
`ifdef FIFO_UMBRAL_HWM_EN
        , output hwm
`endif
    );

endinterface

// File: rtl/fifo_umbral_mem.sv
// Register file for the FIFO: synchronous write, registered read that holds
// its last word when no read is issued.
module fifo_umbral_mem #(
    parameter int DATA_W = fifo_umbral_pkg::DATA_W,
    parameter int ADDR_W = fifo_umbral_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    import fifo_umbral_pkg::*;

    logic [DATA_W-1:0] mem_q [1 << ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with live almost-full/almost-empty thresholds and a sticky error flag.
// Define FIFO_UMBRAL_HWM_EN to add the registered high-water-mark output.
module fifo_umbral #(
    parameter int DATA_W = fifo_umbral_pkg::DATA_W,
    parameter int ADDR_W = fifo_umbral_pkg::ADDR_W,
    parameter int U_W    = fifo_umbral_pkg::U_W
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbral_if.slave  bus
);
    import fifo_umbral_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q;
    logic              error_q, error_d;
    logic              is_empty, is_full;
    logic              do_wr, do_rd, ovf, unf;
    logic [U_W-1:0]    count_ext;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_CNT);

    // A read alongside a write on a full queue frees the slot the write lands in.
    assign do_rd = bus.rd_en && !is_empty;
    assign do_wr = bus.wr_en && (!is_full || bus.rd_en);
    assign ovf   = bus.wr_en && is_full && !bus.rd_en;
    assign unf   = bus.rd_en && is_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(do_wr);
        rd_ptr_d = rd_ptr_q + ADDR_W'(do_rd);
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        error_d = error_q | ovf | unf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= do_rd;
            error_q  <= error_d;
        end
    end

    fifo_umbral_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (do_wr && !reset),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_in),
        .rd_en_i   (do_rd && !reset),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.data_out)
    );

    // Thresholds are compared live against the zero-extended occupancy.
    assign count_ext        = U_W'(count_q);
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (count_ext >= bus.umbral_alto);
    assign bus.almost_empty = (count_ext <= bus.umbral_bajo);
    assign bus.valid_out    = valid_q;
    assign bus.error        = error_q;

`ifdef FIFO_UMBRAL_HWM_EN
    logic [ADDR_W:0] hwm_q, hwm_d;

    assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed plus randomized bench for fifo_umbral against a queue-based reference model.
// Also checks the high-water mark when built with FIFO_UMBRAL_HWM_EN.
module tb_fifo_umbral;
    import fifo_umbral_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state
    logic [DATA_W-1:0] q_m[$];
    logic              err_m;
    logic              valid_m;
    logic [DATA_W-1:0] dout_m;
    int                hwm_m;
    err_cause_e        cause_m;

    fifo_umbral_if bus ();

    fifo_umbral dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q_m.size();
        chk({tag, ".count"}, 32'(bus.count), 32'(n));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= int'(bus.umbral_alto)));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= int'(bus.umbral_bajo)));
        chk({tag, ".error"}, 32'(bus.error), 32'(err_m));
        chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(valid_m));
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(dout_m));
`ifdef FIFO_UMBRAL_HWM_EN
        chk({tag, ".hwm"}, 32'(bus.hwm), 32'(hwm_m));
`endif
    endtask

    // One clock of stimulus: drive, let the edge pass, advance the model, check.
    task automatic step(input string tag, input logic w, input logic [DATA_W-1:0] d,
                        input logic r, input logic rst);
        bit was_full, was_empty;
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = r;
        reset       = rst;
        @(posedge clk);
        was_full  = (q_m.size() == DEPTH);
        was_empty = (q_m.size() == 0);
        cause_m   = ERR_NONE;
        if (rst) begin
            q_m.delete();
            err_m   = 1'b0;
            valid_m = 1'b0;
            dout_m  = '0;
            hwm_m   = 0;
        end else begin
            if (r && was_empty) cause_m = ERR_UNF;
            if (w && was_full && !r) cause_m = ERR_OVF;
            if (cause_m != ERR_NONE) err_m = 1'b1;
            if (r && !was_empty) begin
                dout_m  = q_m.pop_front();
                valid_m = 1'b1;
            end else begin
                valid_m = 1'b0;
            end
            if (w && (!was_full || r)) q_m.push_back(d);
            if (q_m.size() > hwm_m) hwm_m = q_m.size();
        end
        #1;
        $display("%s t=%0t rst=%0b wr=%0b din=%02h rd=%0b -> count=%0d dout=%02h valid=%0b err=%0b cause=%s",
                 tag, $time, rst, w, d, r, bus.count, bus.data_out, bus.valid_out, bus.error,
                 cause_m.name());
        check_all(tag);
    endtask

    initial begin
        bus.wr_en       = 1'b0;
        bus.data_in     = '0;
        bus.rd_en       = 1'b0;
        bus.umbral_alto = 4'd6;
        bus.umbral_bajo = 4'd1;
        reset           = 1'b1;
        q_m.delete();
        err_m   = 1'b0;
        valid_m = 1'b0;
        dout_m  = '0;
        hwm_m   = 0;

        // 1: reset then idle
        step("reset", 1'b0, '0, 1'b0, 1'b1);
        step("idle", 1'b0, '0, 1'b0, 1'b0);
        chk("idle.almost_empty_const", 32'(bus.almost_empty), 32'd1);

        // 2: fill with 0x01..0x08, thresholds 6/1
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        chk("fill.full_const", 32'(bus.full), 32'd1);

        // 3: overflow, then drain and confirm order
        step("ovf", 1'b1, 6'h3F, 1'b0, 1'b0);
        chk("ovf.error_const", 32'(bus.error), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0);
            chk("drain.order", 32'(bus.data_out), 32'(i));
        end
        step("drain_idle", 1'b0, '0, 1'b0, 1'b0);

        // 4: full FIFO with simultaneous read+write, then drain across the wrap
        step("reset4", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step("fill4", 1'b1, DATA_W'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("rdwr_full", 1'b1, DATA_W'(8'h30 + i), 1'b1, 1'b0);
        chk("rdwr_full.error_const", 32'(bus.error), 32'd0);
        for (int i = 0; i < 8; i++) step("wrap_drain", 1'b0, '0, 1'b1, 1'b0);

        // 5: empty FIFO with simultaneous read+write
        step("rdwr_empty", 1'b1, 6'h15, 1'b1, 1'b0);
        step("rd_after", 1'b0, '0, 1'b1, 1'b0);
        chk("rd_after.data_const", 32'(bus.data_out), 32'h15);

        // 6: reset discards queued data; live thresholds
        step("reset6", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("fill6", 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        step("midreset", 1'b1, 6'h2A, 1'b1, 1'b1);
        step("post_reset", 1'b0, '0, 1'b0, 1'b0);
        bus.umbral_alto = 4'd15;
        #1 check_all("alto15");
        bus.umbral_alto = 4'd0;
        #1 check_all("alto0");
        chk("alto0.const", 32'(bus.almost_full), 32'd1);
        for (int i = 0; i < 8; i++) step("fill_thr", 1'b1, DATA_W'(i), 1'b0, 1'b0);
        bus.umbral_alto = 4'd9;
        bus.umbral_bajo = 4'd8;
        #1 check_all("alto9_bajo8");
        bus.umbral_bajo = 4'd7;
        #1 check_all("bajo7");

        // Randomized traffic with occasional threshold changes and resets
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                bus.umbral_alto = 4'($urandom_range(0, 15));
                bus.umbral_bajo = 4'($urandom_range(0, 15));
            end
            step("rand", 1'($urandom_range(0, 99) < 55), DATA_W'($urandom),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Parameterised synchronous FIFO with programmable almost-full/almost-empty thresholds ("umbrales").
- Sits directly downstream of the transaction-layer state machine. It consumes that machine's threshold outputs (one of the umbral_MFs/VCs/Ds values).
- Produces the per-FIFO `empty` and `error` bits that feed the machine's FIFO_empties / FIFO_errors vectors.
- One instance per queue (main, VC, D).

Parameters:
- DATA_W, 6, payload width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W (8).
- U_W, 4, threshold width; must be >= ADDR_W+1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  push request.
- data_in  in  DATA_W  push data.
- rd_en  in  1  pop request.
- data_out  out  DATA_W  popped word, registered.
- valid_out  out  1  data_out holds a word popped on the previous cycle.
- umbral_alto  in  U_W  almost-full threshold (occupancy).
- umbral_bajo  in  U_W  almost-empty threshold (occupancy).
- count  out  ADDR_W+1  current occupancy, 0..depth.
- empty  out  1  count==0.
- full  out  1  count==depth.
- almost_full  out  1  count >= umbral_alto.
- almost_empty  out  1  count <= umbral_bajo.
- error  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge):
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, error=0.
  - Memory contents are not cleared.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-operation discards all queued data; flags read as empty from the next cycle.
- Write: wr_en && !full stores data_in at wr_ptr; wr_ptr increments and wraps modulo depth.
- Read: rd_en && !empty takes mem[rd_ptr] into data_out on the same edge; valid_out=1 the following cycle, so read latency is 1 clock. rd_ptr increments and wraps.
- rd_en deasserted or refused: valid_out=0 next cycle; data_out holds its last value.
- Simultaneous rd_en && wr_en:
  - Not empty and not full: both occur, count unchanged.
  - Full: the read frees a slot and both occur, count stays depth, no error.
  - Empty: the write occurs and the read is refused (underflow), count=1, error set.
- Overflow: wr_en && full && !rd_en discards the write; error set.
- Underflow: rd_en && empty discards the read; error set; valid_out=0.
- error is sticky and is cleared only by reset.
- Flags empty/full/almost_full/almost_empty are combinational from the registered count; the thresholds are live, not latched.
- Threshold comparisons are unsigned, with count zero-extended to U_W.
  - umbral_alto=0 forces almost_full=1.
  - umbral_alto>depth means almost_full never asserts.
  - umbral_bajo>=depth forces almost_empty=1.
- count is maintained as a register, not derived from pointers, and is bounded to 0..depth.

Optional Feature:
- Macro: FIFO_UMBRAL_HWM_EN.
- Defined: adds output port `hwm` (ADDR_W+1 bits), the high-water mark.
  - Registered, takes max(hwm, next count) every cycle.
  - Reset to 0 by reset only.
- Not defined: port and register are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_umbral_pkg holds:
  - Default widths: DATA_W, ADDR_W, U_W.
  - Localparam DEPTH = 1<<ADDR_W.
  - An enum of error causes (ERR_NONE, ERR_OVF, ERR_UNF) for bench reporting.
- One natural sub-module, fifo_umbral_mem:
  - 2**ADDR_W x DATA_W register file.
  - Synchronous write port; read port addressed by rd_ptr.
  - Instantiated once; pointer/count/flag logic stays in the top module.

Test Plan:
1. Reset then idle -> count=0, empty=1, full=0, almost_empty=1 (umbral_bajo=1), error=0, valid_out=0.
2. umbral_alto=6, umbral_bajo=1; push 8 words 0x01..0x08 -> almost_empty drops after the 2nd push, almost_full rises after the 6th, full=1 after the 8th, count=8, error=0.
3. Full FIFO, push 0x3F without read -> write dropped, error=1 from the next cycle. Drain 8 reads -> data_out sequence 0x01..0x08, each with valid_out=1 one cycle after rd_en.
4. Full FIFO, rd_en+wr_en together for 4 cycles -> count stays 8, error stays 0. Wrap-around check: output order preserved across the pointer wrap.
5. Empty FIFO, rd_en+wr_en with data 0x15 -> count=1, error=1, valid_out=0. Next read returns 0x15.
6. Reset asserted with 5 words queued -> next cycle count=0, empty=1, error=0. Change umbral_alto 15->0 live -> almost_full=1 combinationally.
